life_sequencer: RTL and testbench



---
 rtl/life_pkg.sv | 14 +
 rtl/life_sequencer_gen_timer.sv | 29 ++
 rtl/life_sequencer.sv | 108 ++++++++++
 tb/tb_life_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants and state encoding for the Game-of-Life sequencer.
package life_pkg;

    localparam int GRID_SIDE = 8;
    localparam int GRID_W    = GRID_SIDE * GRID_SIDE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } life_state_t;

endpackage

// File: rtl/life_sequencer_gen_timer.sv
// Generation-rate tick counter: counts 0..TICK_DIV-1 while enabled.
// o_tc flags the last tick of the period.
module gen_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/life_sequencer.sv
// Owns the 8x8 life grid and decides when to commit the evolve datapath's
// result: free-run at TICK_DIV cycles per generation, single step, or halt.
module life_sequencer
    import life_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [GRID_W-1:0] seed,
    input  logic              run,
    input  logic              step,
    input  logic [GRID_W-1:0] grid_next,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic [1:0]        state,
    output logic              busy,
    output logic              stable,
    output logic              empty
);

    life_state_t       r_state;
    logic [GRID_W-1:0] r_grid;
    logic [GEN_W-1:0]  r_gen_count;
    logic              r_busy;
    logic              r_stable;

    life_state_t       w_state_next;
    logic              w_commit;
    logic              w_same;
    logic              w_halt_hit;
    logic              w_tc;
    logic              w_timer_clear;

    // Tick is held at zero whenever we are not actively free-running.
    assign w_timer_clear = load || (r_state != RUN) || !run;

    gen_timer #(.TICK_DIV(TICK_DIV)) u_gen_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_timer_clear),
        .i_en    (r_state == RUN),
        .o_tc    (w_tc)
    );

    assign w_same     = (grid_next == r_grid);
    assign w_halt_hit = w_same || (grid_next == '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (run)       w_state_next = RUN;
                else if (step) w_state_next = STEP;
            end
            RUN: begin
                if (!run) begin
                    w_state_next = IDLE;
                end else if (w_tc) begin
                    w_commit = 1'b1;
                    if (w_halt_hit) w_state_next = HALT;
                end
            end
            STEP: begin
                w_commit     = 1'b1;
                w_state_next = w_halt_hit ? HALT : IDLE;
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grid      <= '0;
            r_gen_count <= '0;
            r_busy      <= 1'b0;
            r_stable    <= 1'b0;
        end else if (load) begin
            r_state     <= IDLE;
            r_grid      <= seed;
            r_gen_count <= '0;
            r_busy      <= 1'b0;
            r_stable    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == RUN);
            if (w_commit) begin
                r_grid <= grid_next;
                if (r_gen_count != {GEN_W{1'b1}}) r_gen_count <= r_gen_count + 1'b1;
                if (w_same) r_stable <= 1'b1;
            end
        end
    end

    assign grid      = r_grid;
    assign gen_count = r_gen_count;
    assign state     = r_state;
    assign busy      = r_busy;
    assign stable    = r_stable;
    assign empty     = (r_grid == '0);

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a bounded-edge life evolve model.
module tb_life_sequencer;
    import life_pkg::*;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [63:0] seed = '0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [63:0] grid_next;
    logic [63:0] grid;
    logic [15:0] gen_count;
    logic [1:0]  state;
    logic        busy;
    logic        stable;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Evolve datapath: standard B3/S23 rules, cells beyond the 8x8 edge are dead.
    function automatic logic [63:0] evolve(input logic [63:0] g);
        logic [63:0] n;
        int          cnt;
        int          rr;
        int          cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            if (g[rr*8+cc]) cnt++;
                    end
                end
                n[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    assign grid_next = evolve(grid);

    life_sequencer #(.TICK_DIV(4), .GEN_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .run       (run),
        .step      (step),
        .grid_next (grid_next),
        .grid      (grid),
        .gen_count (gen_count),
        .state     (state),
        .busy      (busy),
        .stable    (stable),
        .empty     (empty)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        n_checks++; if (grid !== 64'h0) begin n_fail++; $display("FAIL reset_grid: got %h want %h", grid, 64'h0); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (stable !== 1'b0) begin n_fail++; $display("FAIL reset_stable: got %b want 0", stable); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_blinker_run;
        do_load(BLINK_H);
        n_checks++; if (grid !== BLINK_H) begin n_fail++; $display("FAIL load_grid: got %h want %h", grid, BLINK_H); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL load_empty: got %b want 0", empty); end
        run = 1'b1;
        cyc(1);
        n_checks++; if (state !== RUN) begin n_fail++; $display("FAIL run_entry_state: got %0d want %0d", state, RUN); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy: got %b want 1", busy); end
        cyc(3);
        n_checks++; if (grid !== BLINK_H) begin n_fail++; $display("FAIL run_early_commit: got %h want %h", grid, BLINK_H); end
        cyc(1);
        n_checks++; if (grid !== BLINK_V) begin n_fail++; $display("FAIL run_gen1_grid: got %h want %h", grid, BLINK_V); end
        n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL run_gen1_count: got %0d want 1", gen_count); end
        cyc(4);
        n_checks++; if (grid !== BLINK_H) begin n_fail++; $display("FAIL run_gen2_grid: got %h want %h", grid, BLINK_H); end
        n_checks++; if (gen_count !== 16'd2) begin n_fail++; $display("FAIL run_gen2_count: got %0d want 2", gen_count); end
        n_checks++; if (stable !== 1'b0) begin n_fail++; $display("FAIL run_stable: got %b want 0", stable); end
        run = 1'b0;
        cyc(1);
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL run_stop_state: got %0d want %0d", state, IDLE); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_stop_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_step;
        do_load(BLINK_H);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        n_checks++; if (state !== STEP) begin n_fail++; $display("FAIL step_state: got %0d want %0d", state, STEP); end
        n_checks++; if (grid !== BLINK_H) begin n_fail++; $display("FAIL step_early: got %h want %h", grid, BLINK_H); end
        cyc(1);
        n_checks++; if (grid !== BLINK_V) begin n_fail++; $display("FAIL step_grid: got %h want %h", grid, BLINK_V); end
        n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL step_count: got %0d want 1", gen_count); end
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL step_done_state: got %0d want %0d", state, IDLE); end
        cyc(3);
        n_checks++; if (grid !== BLINK_V) begin n_fail++; $display("FAIL step_hold: got %h want %h", grid, BLINK_V); end
    endtask

    task automatic test_still_life;
        do_load(BLOCK);
        run = 1'b1;
        cyc(5);
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL still_stable: got %b want 1", stable); end
        n_checks++; if (state !== HALT) begin n_fail++; $display("FAIL still_state: got %0d want %0d", state, HALT); end
        n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL still_count: got %0d want 1", gen_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL still_busy: got %b want 0", busy); end
        cyc(8);
        step = 1'b1;
        cyc(2);
        step = 1'b0;
        run = 1'b0;
        cyc(1);
        n_checks++; if (grid !== BLOCK) begin n_fail++; $display("FAIL halt_grid: got %h want %h", grid, BLOCK); end
        n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL halt_count: got %0d want 1", gen_count); end
        n_checks++; if (state !== HALT) begin n_fail++; $display("FAIL halt_state: got %0d want %0d", state, HALT); end
        do_load(BLINK_H);
        n_checks++; if (stable !== 1'b0 || state !== IDLE) begin n_fail++; $display("FAIL halt_exit: got stable=%b state=%0d want stable=0 state=0", stable, state); end
    endtask

    task automatic test_extinction;
        do_load(SINGLE);
        run = 1'b1;
        cyc(5);
        run = 1'b0;
        n_checks++; if (grid !== 64'h0) begin n_fail++; $display("FAIL ext_grid: got %h want 0", grid); end
        n_checks++; if (state !== HALT) begin n_fail++; $display("FAIL ext_state: got %0d want %0d", state, HALT); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ext_empty: got %b want 1", empty); end
        n_checks++; if (stable !== 1'b0) begin n_fail++; $display("FAIL ext_stable: got %b want 0", stable); end
        n_checks++; if (gen_count !== 16'd1) begin n_fail++; $display("FAIL ext_count: got %0d want 1", gen_count); end
    endtask

    task automatic test_interruptions;
        // Drop run exactly when tick==3: no commit, tick cleared.
        do_load(BLINK_H);
        run = 1'b1;
        cyc(4);
        run = 1'b0;
        cyc(1);
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL drop_state: got %0d want %0d", state, IDLE); end
        n_checks++; if (grid !== BLINK_H || gen_count !== 16'd0) begin n_fail++; $display("FAIL drop_commit: got grid=%h gen=%0d want grid=%h gen=0", grid, gen_count, BLINK_H); end
        run = 1'b1;
        cyc(4);
        n_checks++; if (grid !== BLINK_H) begin n_fail++; $display("FAIL rerun_early: got %h want %h", grid, BLINK_H); end
        // Load on the commit edge: load wins.
        seed = BLOCK;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        run = 1'b0;
        n_checks++; if (grid !== BLOCK) begin n_fail++; $display("FAIL load_mid_grid: got %h want %h", grid, BLOCK); end
        n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL load_mid_count: got %0d want 0", gen_count); end
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL load_mid_state: got %0d want %0d", state, IDLE); end
        // Reset on the commit edge: everything back to reset values.
        cyc(1);
        do_load(BLINK_H);
        run = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        run = 1'b0;
        n_checks++; if (grid !== 64'h0 || gen_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_data: got grid=%h gen=%0d want 0/0", grid, gen_count); end
        n_checks++; if (state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got state=%0d busy=%b want 0/0", state, busy); end
        n_checks++; if (empty !== 1'b1 || stable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got empty=%b stable=%b want 1/0", empty, stable); end
    endtask

    initial begin
        cyc(1);
        test_reset;
        test_blinker_run;
        test_single_step;
        test_still_life;
        test_extinction;
        test_interruptions;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
